// File: rtl/piso_serializer.sv
// piso_serializer: N-word parallel-in/serial-out frame serializer, LSW first,
// with a one-frame holding buffer so back-to-back frames need no idle cycle.
module piso_serializer #(
    parameter int N  = 8,
    parameter int NB = 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [N*NB-1:0] i_data,
    output logic [NB-1:0]   o_data,
    output logic            o_valid,
    output logic            o_last,
    output logic            o_busy
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [N*NB-1:0] r_sreg, r_hold;
    logic [CW-1:0]   r_cnt;
    logic            r_active, r_hold_full;
    logic            w_last, w_consume, w_accept, w_free;

    assign w_last    = r_cnt == CW'(N - 1);
    assign w_consume = r_active & i_enable;
    assign w_accept  = i_valid & ~r_hold_full;
    // the shift register is free if idle or its final word leaves on this edge
    assign w_free    = ~r_active | (w_consume & w_last);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sreg      <= '0;
            r_hold      <= '0;
            r_cnt       <= '0;
            r_active    <= 1'b0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_accept & w_free) begin
                r_sreg   <= i_data;
                r_cnt    <= '0;
                r_active <= 1'b1;
            end else if (w_consume & ~w_last) begin
                r_sreg <= r_sreg >> NB;
                r_cnt  <= r_cnt + CW'(1);
            end else if (r_hold_full & (w_consume | ~r_active)) begin
                r_sreg      <= r_hold;
                r_cnt       <= '0;
                r_active    <= 1'b1;
                r_hold_full <= 1'b0;
            end else if (w_consume) begin
                r_active <= 1'b0;
            end
            if (w_accept & ~w_free) begin
                r_hold      <= i_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign o_data  = r_sreg[NB-1:0];
    assign o_valid = r_active;
    assign o_last  = r_active & w_last;
    assign o_ready = ~r_hold_full;
    assign o_busy  = r_active | r_hold_full;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: vector tables, reset corner case and a randomized
// queue-model/loopback run across three serializer configurations.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v8 = 0, e8 = 0, v4 = 0, e4 = 0, v1 = 0, e1 = 0;
    logic [7:0] d8 = 0, d4 = 0;
    logic [3:0] d1 = 0;
    logic       r8, ov8, l8, b8, r4, ov4, l4, b4, r1, ov1, l1, b1;
    logic       od8;
    logic [1:0] od4;
    logic [3:0] od1;

    piso_serializer #(.N(8), .NB(1)) u8 (
        .i_clock(clk), .i_reset(rst_n), .i_enable(e8), .i_valid(v8), .o_ready(r8),
        .i_data(d8), .o_data(od8), .o_valid(ov8), .o_last(l8), .o_busy(b8));
    piso_serializer #(.N(4), .NB(2)) u4 (
        .i_clock(clk), .i_reset(rst_n), .i_enable(e4), .i_valid(v4), .o_ready(r4),
        .i_data(d4), .o_data(od4), .o_valid(ov4), .o_last(l4), .o_busy(b4));
    piso_serializer #(.N(1), .NB(4)) u1 (
        .i_clock(clk), .i_reset(rst_n), .i_enable(e1), .i_valid(v1), .o_ready(r1),
        .i_data(d1), .o_data(od1), .o_valid(ov1), .o_last(l1), .o_busy(b1));

    typedef struct {
        int         sel;
        logic       v, e;
        logic [7:0] d;
        logic [3:0] xd;
        logic       xv, xl, xr, xb;
    } vec_t;

    int total = 0;
    int bad = 0;

    task automatic chk(string n, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    function automatic vec_t mk(int s, logic v, logic e, logic [7:0] d,
                                logic [3:0] xd, logic xv, logic xl, logic xr, logic xb);
        vec_t t;
        t.sel = s; t.v = v; t.e = e; t.d = d;
        t.xd = xd; t.xv = xv; t.xl = xl; t.xr = xr; t.xb = xb;
        return t;
    endfunction

    task automatic apply(vec_t t);
        v8 = 0; e8 = 0; v4 = 0; e4 = 0; v1 = 0; e1 = 0;
        case (t.sel)
            0: begin v8 = t.v; e8 = t.e; d8 = t.d; end
            1: begin v4 = t.v; e4 = t.e; d4 = t.d; end
            default: begin v1 = t.v; e1 = t.e; d1 = t.d[3:0]; end
        endcase
    endtask

    task automatic outs(int sel, output int od, output int ov, output int ol,
                        output int orr, output int ob);
        case (sel)
            0: begin od = od8; ov = ov8; ol = l8; orr = r8; ob = b8; end
            1: begin od = od4; ov = ov4; ol = l4; orr = r4; ob = b4; end
            default: begin od = od1; ov = ov1; ol = l1; orr = r1; ob = b1; end
        endcase
    endtask

    vec_t       tbl[$];
    logic [7:0] q[$];
    logic [7:0] rx, done, dd;
    int         pos;

    initial begin
        int od, ov, ol, orr, ob;
        // single frame 0xB4 on N=8,NB=1
        tbl.push_back(mk(0, 1, 1, 8'hB4, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
        // back-to-back 0xE4, 0x1B on N=4,NB=2; 0x55 offered while full must be ignored
        tbl.push_back(mk(1, 1, 1, 8'hE4, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 8'h1B, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 8'h55, 2, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 3, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 3, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 2, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0));
        // enable gating with an accept into hold while frozen
        tbl.push_back(mk(1, 1, 1, 8'hE4, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 8'h1B, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 2, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 3, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 3, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 3, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 2, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0));
        // N=1: frames 5, A, 3 back-to-back
        tbl.push_back(mk(2, 1, 1, 8'h05, 4'h5, 1, 1, 1, 1));
        tbl.push_back(mk(2, 1, 1, 8'h0A, 4'hA, 1, 1, 1, 1));
        tbl.push_back(mk(2, 1, 1, 8'h03, 4'h3, 1, 1, 1, 1));
        tbl.push_back(mk(2, 0, 1, 0, 0, 0, 0, 1, 0));

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            outs(s, od, ov, ol, orr, ob);
            chk($sformatf("reset%0d.data", s), od, 0);
            chk($sformatf("reset%0d.valid", s), ov, 0);
            chk($sformatf("reset%0d.last", s), ol, 0);
            chk($sformatf("reset%0d.ready", s), orr, 1);
            chk($sformatf("reset%0d.busy", s), ob, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(posedge clk);
            #1;
            outs(tbl[i].sel, od, ov, ol, orr, ob);
            chk($sformatf("vec%0d.valid", i), ov, int'(tbl[i].xv));
            chk($sformatf("vec%0d.last", i), ol, int'(tbl[i].xl));
            chk($sformatf("vec%0d.ready", i), orr, int'(tbl[i].xr));
            chk($sformatf("vec%0d.busy", i), ob, int'(tbl[i].xb));
            if (tbl[i].xv) chk($sformatf("vec%0d.data", i), od, int'(tbl[i].xd));
            @(negedge clk);
        end

        // reset at word 3 with a frame pending in hold
        v8 = 1; e8 = 1; d8 = 8'h5A;
        @(negedge clk);
        d8 = 8'h33;
        @(negedge clk);
        v8 = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst.data", od8, 1);
        chk("pre_rst.ready", r8, 0);
        chk("pre_rst.busy", b8, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst.valid", ov8, 0);
        chk("rst.busy", b8, 0);
        chk("rst.ready", r8, 1);
        chk("rst.data", od8, 0);
        chk("rst.last", l8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d.valid", i), ov8, 0);
            chk($sformatf("post_rst%0d.busy", i), b8, 0);
        end
        e8 = 0;
        @(negedge clk);

        // randomized run on N=4,NB=2 against a frame-queue model with loopback capture
        pos = 0;
        rx = 0;
        for (int i = 0; i < 400; i++) begin
            logic v, e, acc, popped, lb_end;
            chk("rnd.valid", ov4, int'(q.size() > 0));
            chk("rnd.busy", b4, int'(q.size() > 0));
            chk("rnd.ready", r4, int'(q.size() < 2));
            chk("rnd.last", l4, int'(q.size() > 0 && pos == 3));
            if (q.size() > 0) begin
                dd = q[0] >> (2 * pos);
                chk("rnd.data", od4, int'(dd[1:0]));
            end
            v = (i < 370) && ($urandom_range(0, 9) < 6);
            e = (i >= 370) || ($urandom_range(0, 9) < 7);
            v4 = v; e4 = e; d4 = 8'($urandom);
            lb_end = ov4 && e && l4;
            if (ov4 && e) rx = {od4, rx[7:2]};
            acc = v && q.size() < 2;
            popped = 0;
            if (q.size() > 0 && e) begin
                pos++;
                if (pos == 4) begin
                    done = q.pop_front();
                    pos = 0;
                    popped = 1;
                end
            end
            if (acc) q.push_back(d4);
            if (popped) chk("loopback", lb_end ? int'(rx) : -1, int'(done));
            else if (lb_end) chk("loopback_spurious", 1, 0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("drain.busy", b4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer: accepts an N-word frame of NB-bit words over a valid/ready handshake and emits it one word per enabled cycle, least-significant word first. It is the transmit end for the team's `shift_register` SIPO receiver. With `o_data` wired to that block's `i_data`, `o_valid` wired to its `i_valid`, and a shared `i_enable`, the receiver's `data_out` equals the transmitted frame after N enabled cycles. A one-frame holding buffer allows back-to-back frames with no idle cycle.

## Interface
- `N`, default 8: words per frame, N ≥ 1.
- `NB`, default 1: word width in bits, NB ≥ 1.

- `i_clock`, in, 1: the only clock; all state updates on its rising edge.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_enable`, in, 1: shift enable, e.g. a baud or symbol tick. Output advances only when it is high.
- `i_valid`, in, 1: input frame valid.
- `o_ready`, out, 1: holding buffer can accept a frame.
- `i_data`, in, N*NB: frame. Word k is `i_data[k*NB +: NB]`, and word 0 is sent first.
- `o_data`, out, NB: current serial word.
- `o_valid`, out, 1: `o_data` holds a frame word.
- `o_last`, out, 1: current word is word N-1 of its frame.
- `o_busy`, out, 1: a frame is shifting or pending.

## Operation
- **State:**
  - `sreg` [N*NB]: shift register.
  - `cnt` [clog2(N) bits, min 1]: word index, 0..N-1.
  - `active`: a frame is in `sreg`.
  - `hold` [N*NB] with flag `hold_full`.
- **Outputs:**
  - `o_data = sreg[NB-1:0]`
  - `o_valid = active`
  - `o_last = active & (cnt == N-1)`
  - `o_ready = ~hold_full`
  - `o_busy = active | hold_full`
- **Accept:** `i_valid & o_ready` at a clock edge. `i_data` is sampled on that edge. The frame's destination is decided by `free`:
  - `free` = `~active`, or the current word is being consumed as the last word (`active & i_enable & cnt == N-1`).
  - Accept with `free`: load `sreg ← i_data`, `cnt ← 0`, `active ← 1`. The frame bypasses `hold`.
  - Accept without `free`: load `hold ← i_data`, `hold_full ← 1`.
- **Consume** (`active & i_enable`):
  - If `cnt < N-1`: `sreg ← {NB'b0, sreg[N*NB-1:NB]}` and `cnt ← cnt + 1`.
  - If `cnt == N-1`, the frame ends, and exactly one of the following applies, in priority order:
    1. An accept occurs on the same edge: it loads `sreg` as above.
    2. `hold_full` is set: `sreg ← hold`, `cnt ← 0`, `active` stays 1, `hold_full ← 0`.
    3. Otherwise: `active ← 0`.
  - Cases 1 and 2 are mutually exclusive, because accept requires `hold_full = 0`.
- **Idle with pending frame:** if `~active & hold_full`, the next edge loads `sreg ← hold`, `cnt ← 0`, `active ← 1`, `hold_full ← 0`. This state is unreachable in normal flow, but the logic is required for robustness.
- **Enable low:** `sreg`, `cnt` and `active` freeze, and outputs stay stable. Accepts are still allowed and go into `hold`.
- **N = 1:** every word has `o_last = 1`, and `cnt` stays 0.
- **Reset (async assert):**
  - `sreg`, `hold` and `cnt` go to 0; `active` and `hold_full` go to 0.
  - Outputs become `o_data = 0`, `o_valid = 0`, `o_last = 0`, `o_busy = 0`, `o_ready = 1`.
  - Reset mid-frame discards both the shifting frame and the pending frame, and emits no partial output after deassert.

## Timing
- **Latency:** an accept while idle at edge t gives `o_valid = 1` with word 0 on `o_data` immediately after edge t.
- **Word advance:** each edge with `i_enable = 1` advances one word. With `i_enable` held high, a frame occupies exactly N cycles.
- **Throughput:** a producer that holds `i_valid` high sustains continuous output, with `o_valid` never dropping between frames.
- **`o_ready`:** registered. It falls the cycle after a frame enters `hold`, and rises the cycle after `hold` drains into `sreg`.
- **Handshake:** `i_data` must be stable only on the accepting edge. No combinational path exists from `i_valid` to `o_ready`.

## Test plan
1. **Single frame:** N=8, NB=1, `i_enable` held at 1, one accept of frame 0xB4.
   - Required: `o_data` = 0,0,1,0,1,1,0,1 on 8 consecutive cycles, `o_last` only on the 8th, then `o_valid = 0` and `o_busy = 0`.
2. **Back-to-back:** N=4, NB=2, frames 0xE4 then 0x1B, `i_valid` held high.
   - Required: words 0,1,2,3,3,2,1,0 with no gap in `o_valid`.
   - Required: `o_ready` drops to 0 while the second frame is held.
3. **Enable gating:** `i_enable` = 1,0,0,1,... during a frame.
   - Required: `o_data` and `cnt` hold during the 0 cycles.
   - Required: the total valid span is N enabled cycles, and a frame accepted meanwhile goes to `hold`.
4. **Loopback:** output drives `shift_register` (same N, NB, `i_enable`) with random frames.
   - Required: after each `o_last` consume, the receiver's `data_out` equals the sent frame.
5. **Reset mid-frame:** assert `i_reset = 0` at word 3 with `hold_full = 1`.
   - Required: immediately `o_valid = 0`, `o_busy = 0`, `o_ready = 1`, `o_data = 0`.
   - Required: no words appear after release until a new accept.
6. **N=1 edge case:** N=1, NB=4, `i_valid` held high with frames 5, A, 3.
   - Required: `o_data` = 5, A, 3 on consecutive cycles, each with `o_last = 1`.
